// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle for the multi-cycle
// M-extension multiply/divide sequencer.
//   start_valid/start_ready : request handshake; op, data1, data2 ride with it
//   flush                   : abort whatever is in flight
//   result/result_valid/result_err/result_ack : held response and its ack
//   busy                    : sequencer is anywhere but IDLE
// master = requester/consumer side, slave = sequencer side.
interface muldiv_sequencer_if;
    logic        start_valid;
    logic        start_ready;
    logic [4:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack;
    logic        result_err;
    logic        busy;

    modport master (
        output start_valid, op, data1, data2, flush, result_ack,
        input  start_ready, result, result_valid, result_err, busy
    );

    modport slave (
        input  start_valid, op, data1, data2, flush, result_ack,
        output start_ready, result, result_valid, result_err, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32 M-extension unit.
//   MUL-class ops finish 2 edges after accept, DIV-class ops run a 32-step
//   restoring divider plus a sign-fix cycle (34 edges), illegal ops answer
//   with result 0 and result_err after 1 edge.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_sequencer_if.slave (handshake, operands, result, flush)
// Build option:
//   MULDIV_FASTPATH_EN : divide-by-zero and signed overflow skip the
//                        iterative divider and finish 2 edges after accept.
//
// state  | meaning
// IDLE   | waiting for a request, start_ready high
// MUL    | forming the 64-bit product, selecting low/high word
// DIV    | one restoring iteration per edge, 32 in total
// FIX    | applying signs and selecting quotient or remainder
// DONE   | result held valid until result_ack
module muldiv_sequencer (
    input  logic              clk,
    input  logic              reset_n,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] quo_q, rem_q;
    logic [31:0] result_q;
    logic        err_q;
    logic [5:0]  iter_cnt;

    logic        accept, op_legal, in_signed_div;
    logic [31:0] in_a_mag;
    logic        div_signed, rem_sel, a_neg, b_neg, b_zero;
    logic [31:0] b_mag;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] rem_sh, diff;
    logic [31:0] quo_s, rem_s, fix_result;
`ifdef MULDIV_FASTPATH_EN
    logic        div_special;
    logic [31:0] special_result;
`endif

    assign bus.start_ready  = (state == S_IDLE) && reset_n;
    assign bus.busy         = (state != S_IDLE);
    assign bus.result_valid = (state == S_DONE);
    assign bus.result       = result_q;
    assign bus.result_err   = err_q;

    assign accept        = bus.start_valid && bus.start_ready && !bus.flush;
    assign op_legal      = (bus.op[4:3] == 2'b01);
    assign in_signed_div = bus.op[2] && !bus.op[0];
    // The shift register that becomes the quotient starts as the dividend magnitude.
    assign in_a_mag      = (in_signed_div && bus.data1[31]) ? -bus.data1 : bus.data1;

    // op_q[1:0] for div: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    assign div_signed = !op_q[0];
    assign rem_sel    = op_q[1];
    assign a_neg      = div_signed && a_q[31];
    assign b_neg      = div_signed && b_q[31];
    assign b_zero     = (b_q == 32'd0);
    assign b_mag      = b_neg ? -b_q : b_q;

    // op_q[1:0] for mul: 00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
    assign a_ext = {{32{a_q[31] && (op_q != 2'b10)}}, a_q};
    assign b_ext = {{32{b_q[31] && !op_q[1]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, b_mag};

    // Sign fix-up; divide by zero must report all-ones regardless of dividend sign.
    assign quo_s      = b_zero ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -quo_q : quo_q);
    assign rem_s      = a_neg ? -rem_q : rem_q;
    assign fix_result = rem_sel ? rem_s : quo_s;

`ifdef MULDIV_FASTPATH_EN
    assign div_special    = b_zero || (div_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF));
    assign special_result = rem_sel ? (b_zero ? a_q : 32'd0)
                                    : (b_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op_legal)      state_nxt = S_DONE;
                    else if (bus.op[2]) state_nxt = S_DIV;
                    else                state_nxt = S_MUL;
                end
            end
            S_MUL: state_nxt = S_DONE;
            S_DIV: begin
`ifdef MULDIV_FASTPATH_EN
                if (iter_cnt == 6'd32 && div_special) state_nxt = S_DONE;
                else
`endif
                if (iter_cnt == 6'd1) state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (bus.result_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            iter_cnt <= 6'd0;
        end else if (bus.flush) begin
            err_q    <= 1'b0;
            iter_cnt <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= bus.op[1:0];
                        a_q      <= bus.data1;
                        b_q      <= bus.data2;
                        quo_q    <= in_a_mag;
                        rem_q    <= 32'd0;
                        iter_cnt <= 6'd32;
                        if (!op_legal) begin
                            result_q <= 32'd0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                S_MUL: result_q <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                S_DIV: begin
                    iter_cnt <= iter_cnt - 6'd1;
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
`ifdef MULDIV_FASTPATH_EN
                    if (iter_cnt == 6'd32 && div_special) result_q <= special_result;
`endif
                end
                S_FIX:  result_q <= fix_result;
                S_DONE: if (bus.result_ack) err_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   ack_hold = 0;
    int   last_ack_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the M-extension arithmetic rules.
    function automatic logic [32:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (op[4:3] != 2'b01) return {1'b1, 32'd0};
        case (op[2:0])
            3'd0: begin p = sa * sb;           return {1'b0, p[31:0]};  end
            3'd1: begin p = sa * sb;           return {1'b0, p[63:32]}; end
            3'd2: begin p = ua * ub;           return {1'b0, p[63:32]}; end
            3'd3: begin p = sa * longint'(ub); return {1'b0, p[63:32]}; end
            3'd4: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
                p = sa / sb; return {1'b0, p[31:0]};
            end
            3'd5: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                p = ua / ub; return {1'b0, p[31:0]};
            end
            3'd6: begin
                if (b == 0) return {1'b0, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0};
                p = sa % sb; return {1'b0, p[31:0]};
            end
            default: begin
                if (b == 0) return {1'b0, a};
                p = ua % ub; return {1'b0, p[31:0]};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[4:3] != 2'b01) return 1;
        if (!op[2]) return 2;
`ifdef MULDIV_FASTPATH_EN
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
        return 34;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit keep_valid, input bit push, output int acc);
        int          guard;
        logic [32:0] r;
        exp_t        e;
        guard = 0;
        acc = -1;
        @(negedge clk);
        while (!bus.start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.start_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_ready_timeout: got 0 after %0d cycles, expected 1", guard);
            return;
        end
        bus.op          = op;
        bus.data1       = a;
        bus.data2       = b;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = edge_cnt;
        if (push) begin
            r     = ref_model(op, a, b);
            e.res = r[31:0];
            e.err = r[32];
            e.lat = ref_latency(op, a, b);
            e.acc = acc;
            exp_q.push_back(e);
        end
        if (!keep_valid) bus.start_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !bus.start_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (exp_q.size() != 0 || !bus.start_ready) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented, then acks it.
    initial begin
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (reset_n && bus.result_valid) begin
                have = 1'b0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got result %h, expected no result", bus.result);
                end else begin
                    have = 1'b1;
                    e = exp_q.pop_front();
                    check("result", bus.result, e.res);
                    check("result_err", {31'd0, bus.result_err}, {31'd0, e.err});
                    check("latency", edge_cnt - e.acc + 1, e.lat);
                    for (int i = 0; i < ack_hold; i++) begin
                        @(negedge clk);
                        check("hold_valid", {31'd0, bus.result_valid}, 32'd1);
                        check("hold_result", bus.result, e.res);
                    end
                end
                bus.result_ack = 1'b1;
                @(posedge clk);
                #1;
                last_ack_edge = edge_cnt;
                @(negedge clk);
                bus.result_ack = 1'b0;
                check("post_ack_valid", {31'd0, bus.result_valid}, 32'd0);
                check("post_ack_err", {31'd0, bus.result_err}, 32'd0);
                check("post_ack_busy", {31'd0, bus.busy}, 32'd0);
                if (have) check("post_ack_result", bus.result, e.res);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    initial begin
        vec_t        dir[$];
        int          acc, acc2;
        bit          seen_valid;
        logic [4:0]  rop;

        bus.start_valid = 1'b0;
        bus.op          = 5'd0;
        bus.data1       = 32'd0;
        bus.data2       = 32'd0;
        bus.flush       = 1'b0;
        bus.result_ack  = 1'b0;

        #1;
        check("rst_result", bus.result, 32'd0);
        check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_err", {31'd0, bus.result_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ready", {31'd0, bus.start_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        dir = '{
            '{5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{5'b01000, 32'd7,         32'd6},
            '{5'b01011, 32'hFFFF_FFFF, 32'd2},
            '{5'b01100, 32'hFFFF_FFF9, 32'd2},
            '{5'b01110, 32'hFFFF_FFF9, 32'd2},
            '{5'b01111, 32'd7,         32'd2},
            '{5'b01101, 32'd5,         32'd0},
            '{5'b01110, 32'd5,         32'd0},
            '{5'b01100, 32'hFFFF_FFF9, 32'd0},
            '{5'b01100, 32'h8000_0000, 32'hFFFF_FFFF},
            '{5'b01110, 32'h8000_0000, 32'hFFFF_FFFF},
            '{5'b00000, 32'd1,         32'd2},
            '{5'b10000, 32'd3,         32'd4}
        };
        foreach (dir[i]) begin
            ack_hold = 0;
            issue(dir[i].op, dir[i].a, dir[i].b, 1'b0, 1'b1, acc);
            drain();
        end

        // Result must stay put while the consumer stalls.
        ack_hold = 5;
        issue(5'b01000, 32'd123, 32'd456, 1'b0, 1'b1, acc);
        drain();
        ack_hold = 0;

        // start_valid held high across two operations.
        issue(5'b01000, 32'd3, 32'd4, 1'b1, 1'b1, acc);
        issue(5'b01010, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, acc2);
        check("accept_gap", acc2 - last_ack_edge, 32'd1);
        drain();

        // Flush in the middle of a divide.
        issue(5'b01101, 32'h0001_0000, 32'd3, 1'b0, 1'b0, acc);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_flush_busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_ready", {31'd0, bus.start_ready}, 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid) seen_valid = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen_valid}, 32'd0);

        // Reset pulse mid-divide, between clock edges.
        issue(5'b01100, 32'd1000, 32'd7, 1'b0, 1'b1, acc);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_result", bus.result, 32'd0);
        check("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("midrst_err", {31'd0, bus.result_err}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_ready", {31'd0, bus.start_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        issue(5'b01000, 32'd9, 32'd11, 1'b0, 1'b1, acc);
        drain();

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rop = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(16, 31));
            end else begin
                rop = 5'($urandom_range(8, 15));
            end
            ack_hold = $urandom_range(0, 2);
            issue(rop, pick_operand(), pick_operand(), 1'b0, 1'b1, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RESET_N  input  1  asynchronous, active-low reset.
REQ-003 START_VALID  input  1  requester presents an operation.
REQ-004 START_READY  output  1  sequencer can accept; high only in IDLE and while RESET_N is high.
REQ-005 OP  input  5  M-extension select: 01000 MUL, 01001 MULH, 01010 MULHU, 01011 MULHSU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-006 DATA1, DATA2  input  32 each  operand 1 (multiplicand/dividend) and operand 2 (multiplier/divisor).
REQ-007 FLUSH  input  1  abort any in-flight operation.
REQ-008 RESULT  output  32  registered result.
REQ-009 RESULT_VALID  output  1  RESULT is valid, held until acknowledged.
REQ-010 RESULT_ACK  input  1  consumer takes RESULT.
REQ-011 RESULT_ERR  output  1  qualifies RESULT_VALID; OP was outside 01000-01111.
REQ-012 BUSY  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX and DONE.
REQ-014 Accept SHALL occur on an edge with START_VALID=1, START_READY=1 and FLUSH=0; OP, DATA1 and DATA2 are latched on that edge.
REQ-015 On accept, MUL-class OP SHALL go to MUL, DIV-class OP to DIV, and illegal OP to DONE with RESULT=0 and RESULT_ERR=1.
REQ-016 MUL SHALL form the 64-bit product with signedness per OP: MUL and MULH signed*signed, MULHU unsigned*unsigned, MULHSU signed DATA1 * unsigned DATA2; it then registers the low word for MUL and the high word otherwise and moves to DONE on the next edge.
REQ-017 MUL-class latency SHALL be exactly 2 edges from accept to RESULT_VALID=1.
REQ-018 DIV SHALL perform 32 restoring radix-2 iterations, one per edge, on operand magnitudes for signed ops and raw values for unsigned ops, using a 6-bit iteration counter; after the 32nd iteration it moves to FIX.
REQ-019 FIX SHALL apply signs (quotient negative iff operand signs differ, remainder takes dividend sign), select quotient or remainder, register RESULT and move to DONE; DIV-class latency is 34 edges.
REQ-020 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = DATA1, for both signed and unsigned ops.
REQ-021 Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF) SHALL return DIV 0x80000000 and REM 0.
REQ-022 In DONE, RESULT_VALID SHALL be 1 and RESULT and RESULT_ERR SHALL be stable; an edge with RESULT_ACK=1 returns to IDLE and clears RESULT_VALID and RESULT_ERR, while RESULT keeps its last value.
REQ-023 No accept SHALL occur in the DONE-to-IDLE edge; the minimum gap between accepts is therefore 1 IDLE cycle.
REQ-024 FLUSH=1 on any edge SHALL force IDLE, clear RESULT_VALID and RESULT_ERR, and discard in-flight work; it overrides both START_VALID and RESULT_ACK.
REQ-025 RESULT_ACK outside DONE SHALL be ignored.

Reset
REQ-026 While RESET_N=0, state SHALL be IDLE, RESULT=0, RESULT_VALID=0, RESULT_ERR=0, BUSY=0, START_READY=0 and the iteration counter=0, independent of CLK.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; the first accept can occur on the first edge after RESET_N rises.

Configuration
REQ-028 With MULDIV_FASTPATH_EN defined, divide by zero and signed overflow SHALL bypass DIV and FIX, moving directly to DONE with the REQ-020/021 values, for a latency of 2 edges.
REQ-029 Without MULDIV_FASTPATH_EN, those cases SHALL run the full DIV/FIX sequence with 34-edge latency and bit-identical results.

Verification
REQ-030 MULH 0xFFFFFFFF * 0xFFFFFFFF -> RESULT 0x00000000 at 2 edges; MULHU with the same operands -> 0xFFFFFFFE; MUL 7*6 -> 0x0000002A.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD after 34 edges; REM with the same operands -> 0xFFFFFFFF; REMU 7 / 2 -> 1.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, at 2 edges with MULDIV_FASTPATH_EN defined and at 34 edges without it.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM with the same operands -> 0; OP 00000 -> RESULT 0 with RESULT_ERR=1 at 1 edge.
REQ-034 Hold RESULT_ACK low for 5 cycles in DONE -> RESULT stable; FLUSH at DIV iteration 10 -> IDLE next edge with RESULT_VALID never asserted; START_VALID held high throughout -> no second accept until 1 IDLE cycle after RESULT_ACK.
REQ-035 Pulse RESET_N low mid-DIV, between clock edges -> all outputs reach reset values immediately; after release, a new MUL completes in 2 edges.
